// File: rtl/reg_file_sb_if.sv
// Register-file bus: writeback, operand read, issue/flush scoreboard control.
// The pipeline side is the master; the register file is the slave.
interface reg_file_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
) ();

  logic                  write_en;
  logic [AW-1:0]         wa;
  logic [XLEN-1:0]       wd;
  logic [NRD*AW-1:0]     ra;
  logic [NRD*XLEN-1:0]   rdata;
  logic [NRD-1:0]        busy;
  logic                  iss_en;
  logic [AW-1:0]         iss_rd;
  logic                  flush;
  logic [(2**AW)-1:0]    pend;

  modport master (
    output write_en, wa, wd, ra, iss_en, iss_rd, flush,
    input  rdata, busy, pend
  );

  modport slave (
    input  write_en, wa, wd, ra, iss_en, iss_rd, flush,
    output rdata, busy, pend
  );

endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with write-to-read bypass and a single-bit
// pending-write scoreboard used by decode to hold on RAW hazards.
module reg_file_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NRD    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  localparam int unsigned NREGS = 2**AW;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_next;

  // Register array; entry 0 is never written so it reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NREGS; n++) begin
        regs[n] <= '0;
      end
    end else if (bus.write_en && (bus.wa != '0)) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Scoreboard next state: flush drops old marks, a same-edge issue beats retirement.
  always_comb begin
    pend_next = '0;
    for (int unsigned n = 1; n < NREGS; n++) begin
      logic set_n;
      logic clr_n;
      logic keep_n;
      set_n  = bus.iss_en && (bus.iss_rd == AW'(n));
      clr_n  = bus.write_en && (bus.wa == AW'(n));
      keep_n = pend_q[n] && !bus.flush && !clr_n;
      pend_next[n] = set_n || keep_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_next;
    end
  end

  assign bus.pend = pend_q;

  // Read ports resolve independently; reset forces them quiet even if wd is being driven.
  always_comb begin
    bus.rdata = '0;
    bus.busy  = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic          fwd;
      a   = bus.ra[i*AW +: AW];
      fwd = BYPASS && bus.write_en && (bus.wa == a);
      if (!rst && (a != '0)) begin
        bus.rdata[i*XLEN +: XLEN] = fwd ? bus.wd : regs[a];
        bus.busy[i]               = pend_q[a] && !fwd;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing and a non-bypassing instance
// share stimulus and are checked every cycle against a behavioural model.
module tb_reg_file_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;

  logic clk;
  logic rst;
  logic            write_en;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic [NRD*AW-1:0] ra;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic            flush;

  int total_checks  = 0;
  int passed_checks = 0;

  reg_file_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) b1 ();
  reg_file_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) b0 ();

  assign b1.write_en = write_en;  assign b0.write_en = write_en;
  assign b1.wa       = wa;        assign b0.wa       = wa;
  assign b1.wd       = wd;        assign b0.wd       = wd;
  assign b1.ra       = ra;        assign b0.ra       = ra;
  assign b1.iss_en   = iss_en;    assign b0.iss_en   = iss_en;
  assign b1.iss_rd   = iss_rd;    assign b0.iss_rd   = iss_rd;
  assign b1.flush    = flush;     assign b0.flush    = flush;

  reg_file_sb #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(b1)
  );
  reg_file_sb #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .bus(b0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed_checks, total_checks);
    $fatal(1, "watchdog");
  end

  // Behavioural model: architectural registers and pending set.
  logic [XLEN-1:0] m_regs [32];
  logic [31:0]     m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0;
      for (int n = 0; n < 32; n++) m_regs[n] = '0;
    end else begin
      if (flush) m_pend = '0;
      if (write_en) m_pend[wa] = 1'b0;
      if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      if (write_en && wa != 0) m_regs[wa] = wd;
    end
  end

  function automatic logic [XLEN-1:0] exp_rdata(int i, bit bp);
    logic [AW-1:0] a;
    a = ra[i*AW +: AW];
    if (rst || a == 0) return '0;
    if (bp && write_en && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(int i, bit bp);
    logic [AW-1:0] a;
    a = ra[i*AW +: AW];
    if (rst || a == 0) return 1'b0;
    return m_pend[a] && !(bp && write_en && wa == a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("rdata%0d_byp", i), 64'(b1.rdata[i*XLEN +: XLEN]), 64'(exp_rdata(i, 1'b1)));
      check($sformatf("busy%0d_byp", i),  64'(b1.busy[i]),               64'(exp_busy(i, 1'b1)));
      check($sformatf("rdata%0d_nb", i),  64'(b0.rdata[i*XLEN +: XLEN]), 64'(exp_rdata(i, 1'b0)));
      check($sformatf("busy%0d_nb", i),   64'(b0.busy[i]),               64'(exp_busy(i, 1'b0)));
    end
    check("pend_byp", 64'(b1.pend), 64'(m_pend));
    check("pend_nb",  64'(b0.pend), 64'(m_pend));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0; wa = '0; wd = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_ra(5'd0, 5'd0);
    tick(); tick();
    mid();
    check("reset_pend", 64'(b1.pend), 64'h0);
    rst = 1'b0;
    tick();

    // Fill every register and mark every register pending.
    for (int r = 1; r < 32; r++) begin
      write_en = 1'b1; wa = AW'(r); wd = 32'(r) * 32'h0101_0101;
      iss_en = 1'b1; iss_rd = AW'(r);
      set_ra(AW'(r - 1), AW'(r));
      tick();
    end
    idle();
    set_ra(5'd3, 5'd4);
    mid();
    check("fill_pend",   64'(b1.pend), 64'hFFFF_FFFE);
    check("fill_rdata0", 64'(b1.rdata[31:0]), 64'h0303_0303);
    check("fill_busy",   64'(b1.busy), 64'h3);

    // Async reset mid-cycle with writeback and issue active.
    write_en = 1'b1; wa = 5'd2; wd = 32'hCAFE_0002;
    iss_en = 1'b1; iss_rd = 5'd2;
    set_ra(5'd3, 5'd5);
    tick();
    #1 rst = 1'b1;
    #1;
    check("rst_async_pend",  64'(b1.pend), 64'h0);
    check("rst_async_rdata", 64'(b1.rdata), 64'h0);
    check("rst_async_busy",  64'(b1.busy), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    idle();
    set_ra(5'd2, 5'd3);
    mid();
    check("post_rst_pend",   64'(b1.pend), 64'h4);
    check("post_rst_rdata",  64'(b1.rdata), {32'h0, 32'hCAFE_0002});
    tick();

    // x0: writes and issues to register 0 have no effect.
    write_en = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF;
    iss_en = 1'b1; iss_rd = 5'd0;
    set_ra(5'd0, 5'd0);
    mid();
    check("x0_rdata", 64'(b1.rdata), 64'h0);
    check("x0_busy",  64'(b1.busy), 64'h0);
    tick();
    idle();
    mid();
    check("x0_pend0", 64'(b1.pend[0]), 64'h0);
    tick();

    // Bypass versus array-only read.
    write_en = 1'b1; wa = 5'd5; wd = 32'h1111;
    tick();
    wd = 32'h2222;
    set_ra(5'd5, 5'd5);
    mid();
    check("bypass_rdata", 64'(b1.rdata), 64'h0000_2222_0000_2222);
    check("bypass_busy",  64'(b1.busy), 64'h0);
    check("nobyp_rdata",  64'(b0.rdata), 64'h0000_1111_0000_1111);
    tick();

    // RAW hold on register 7.
    idle();
    iss_en = 1'b1; iss_rd = 5'd7;
    set_ra(5'd0, 5'd7);
    tick();
    idle();
    mid();
    check("raw_busy_n1", 64'(b1.busy[1]), 64'h1);
    tick();
    mid();
    check("raw_busy_n2", 64'(b1.busy[1]), 64'h1);
    tick();
    write_en = 1'b1; wa = 5'd7; wd = 32'h7;
    mid();
    check("raw_busy_wb",    64'(b1.busy[1]), 64'h0);
    check("raw_rdata_wb",   64'(b1.rdata[63:32]), 64'h7);
    check("raw_busy_wb_nb", 64'(b0.busy[1]), 64'h1);
    tick();
    idle();
    mid();
    check("raw_pend7", 64'(b1.pend[7]), 64'h0);
    tick();

    // Set/clear collision on register 9.
    iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    write_en = 1'b1; wa = 5'd9; wd = 32'h99;
    tick();
    idle();
    mid();
    check("collide_pend9", 64'(b1.pend[9]), 64'h1);
    write_en = 1'b1; wa = 5'd9; wd = 32'h999;
    tick();

    // Flush drops older marks but keeps the same-cycle issue.
    idle();
    iss_en = 1'b1; iss_rd = 5'd3; tick();
    iss_rd = 5'd4; tick();
    iss_rd = 5'd6; tick();
    flush = 1'b1; iss_rd = 5'd8; tick();
    idle();
    mid();
    check("flush_pend", 64'(b1.pend), 64'h0000_0100);
    write_en = 1'b1; wa = 5'd4; wd = 32'h44;
    tick();
    idle();
    set_ra(5'd4, 5'd8);
    mid();
    check("late_wb_pend",  64'(b1.pend), 64'h0000_0100);
    check("late_wb_rdata", 64'(b1.rdata[31:0]), 64'h44);
    check("late_wb_busy",  64'(b1.busy), 64'h2);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
